// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared encodings for the LSU: RV32 funct3 sizes, FSM states, byte-lane masks and op legality.
package ysyx_23060201_lsu_pkg;

  localparam logic [2:0] Funct3B  = 3'b000;
  localparam logic [2:0] Funct3H  = 3'b001;
  localparam logic [2:0] Funct3W  = 3'b010;
  localparam logic [2:0] Funct3BU = 3'b100;
  localparam logic [2:0] Funct3HU = 3'b101;

  localparam logic [3:0] LaneB = 4'b0001;
  localparam logic [3:0] LaneH = 4'b0011;
  localparam logic [3:0] LaneW = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } lsu_state_e;

  // An op with neither load nor store set is legal; it simply performs no access.
  function automatic logic lsu_op_legal(input logic       is_load,
                                        input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if (is_load && is_store) begin
      ok = 1'b0;
    end else if (!is_load && !is_store) begin
      ok = 1'b1;
    end else begin
      case (funct3)
        Funct3B:  ok = 1'b1;
        Funct3H:  ok = !off[0];
        Funct3W:  ok = (off == 2'b00);
        Funct3BU: ok = is_load;
        Funct3HU: ok = is_load && !off[0];
        default:  ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_align.sv
// Byte-lane alignment: lane mask and shifted store data for issue, extended load data on return.
module ysyx_23060201_lsu_align
  import ysyx_23060201_lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  mask,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [4:0]  sh_amt;
  logic [31:0] rdata_sh;

  assign sh_amt   = {off, 3'b000};
  assign wdata_sh = wdata << sh_amt;
  assign rdata_sh = rdata >> sh_amt;

  always_comb begin
    mask = LaneW;
    case (funct3[1:0])
      2'b00:   mask = LaneB << off;
      2'b01:   mask = LaneH << off;
      default: mask = LaneW;
    endcase
  end

  always_comb begin
    rdata_ext = rdata_sh;
    case (funct3)
      Funct3B:  rdata_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      Funct3H:  rdata_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      Funct3BU: rdata_ext = {24'h0, rdata_sh[7:0]};
      Funct3HU: rdata_ext = {16'h0, rdata_sh[15:0]};
      default:  rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: accepts one op from EXU, drives memory for a single cycle, waits out the
// memory latency and hands the extended result to WBU.
module ysyx_23060201_lsu
  import ysyx_23060201_lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_is_load,
  input  logic                  in_is_store,
  input  logic [2:0]            in_funct3,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_err,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [7:0]            mem_rmask,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_wen,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [7:0]            mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata
);

  localparam logic [3:0] WaitLast = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  lsu_state_e      state_q;
  logic            is_load_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [3:0]      cnt_q;

  logic [2:0]      al_funct3;
  logic [1:0]      al_off;
  logic [3:0]      al_mask;
  logic [31:0]     al_wdata;
  logic [31:0]     al_rdata;
  logic            legal;
  logic [ADDR_WIDTH-1:0] word_addr;

  // In IDLE the aligner sees the incoming op; afterwards it sees the latched one.
  assign al_funct3 = (state_q == StIdle) ? in_funct3 : funct3_q;
  assign al_off    = (state_q == StIdle) ? in_addr[1:0] : off_q;
  assign legal     = lsu_op_legal(in_is_load, in_is_store, in_funct3, in_addr[1:0]);
  assign word_addr = {in_addr[ADDR_WIDTH-1:2], 2'b00};

  ysyx_23060201_lsu_align u_align (
    .funct3    (al_funct3),
    .off       (al_off),
    .wdata     (in_wdata),
    .rdata     (mem_rdata),
    .mask      (al_mask),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      is_load_q <= 1'b0;
      funct3_q  <= 3'b000;
      off_q     <= 2'b00;
      cnt_q     <= 4'd0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_rdata <= '0;
      out_err   <= 1'b0;
      mem_ren   <= 1'b0;
      mem_raddr <= '0;
      mem_rmask <= 8'h00;
      mem_wen   <= 1'b0;
      mem_waddr <= '0;
      mem_wmask <= 8'h00;
      mem_wdata <= '0;
    end else begin
      // Enables are single-cycle pulses: they drop on every edge unless raised below.
      mem_ren <= 1'b0;
      mem_wen <= 1'b0;
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            is_load_q <= in_is_load;
            funct3_q  <= in_funct3;
            off_q     <= in_addr[1:0];
            in_ready  <= 1'b0;
            if (!legal) begin
              state_q   <= StDone;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= '0;
            end else if (!in_is_load && !in_is_store) begin
              state_q   <= StDone;
              out_valid <= 1'b1;
              out_err   <= 1'b0;
              out_rdata <= '0;
            end else begin
              state_q <= StIssue;
              out_err <= 1'b0;
              if (in_is_load) begin
                mem_ren   <= 1'b1;
                mem_raddr <= word_addr;
                mem_rmask <= {4'b0000, al_mask};
              end else begin
                mem_wen   <= 1'b1;
                mem_waddr <= word_addr;
                mem_wmask <= {4'b0000, al_mask};
                mem_wdata <= al_wdata;
              end
            end
          end
        end
        StIssue: begin
          out_rdata <= is_load_q ? al_rdata : '0;
          if (WAIT_CYCLES == 0) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
          end else begin
            state_q <= StWait;
            cnt_q   <= 4'd0;
          end
        end
        StWait: begin
          if (cnt_q == WaitLast) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Directed bench for the LSU: a vector table on a zero-wait instance plus stall and
// reset-mid-op sequences on a three-wait instance.
module tb_ysyx_23060201_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata, mem_rdata;

  logic        in_valid0, out_ready0, in_ready0, out_valid0, out_err0, mem_ren0, mem_wen0;
  logic [31:0] out_rdata0, mem_raddr0, mem_waddr0, mem_wdata0;
  logic [7:0]  mem_rmask0, mem_wmask0;

  logic        in_valid3, out_ready3, in_ready3, out_valid3, out_err3, mem_ren3, mem_wen3;
  logic [31:0] out_rdata3, mem_raddr3, mem_waddr3, mem_wdata3;
  logic [7:0]  mem_rmask3, mem_wmask3;

  always #5 clk = ~clk;

  ysyx_23060201_lsu #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_rdata(out_rdata0), .out_err(out_err0), .mem_ren(mem_ren0), .mem_raddr(mem_raddr0),
    .mem_rmask(mem_rmask0), .mem_rdata(mem_rdata), .mem_wen(mem_wen0), .mem_waddr(mem_waddr0),
    .mem_wmask(mem_wmask0), .mem_wdata(mem_wdata0)
  );

  ysyx_23060201_lsu #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .out_valid(out_valid3), .out_ready(out_ready3),
    .out_rdata(out_rdata3), .out_err(out_err3), .mem_ren(mem_ren3), .mem_raddr(mem_raddr3),
    .mem_rmask(mem_rmask3), .mem_rdata(mem_rdata), .mem_wen(mem_wen3), .mem_waddr(mem_waddr3),
    .mem_wmask(mem_wmask3), .mem_wdata(mem_wdata3)
  );

  typedef struct {
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mword;
    logic        exp_ren;
    logic        exp_wen;
    logic [31:0] exp_maddr;
    logic [7:0]  exp_mask;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[15];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc, vcyc, ren_n, wen_n, exp_lat;
    logic [31:0] raddr, waddr, wd, rd;
    logic [7:0]  rm, wm;
    logic        err;
    string       tag;
    tag     = $sformatf("v%0d", idx);
    exp_lat = (v.exp_err || !(v.ld || v.st)) ? 1 : 2;
    raddr = '0; waddr = '0; wd = '0; rd = '0; rm = '0; wm = '0; err = 1'b0;
    in_is_load  = v.ld;
    in_is_store = v.st;
    in_funct3   = v.f3;
    in_addr     = v.addr;
    in_wdata    = v.wdata;
    mem_rdata   = v.mword;
    out_ready0  = 1'b1;
    in_valid0   = 1'b1;
    chk({tag, " in_ready idle"}, {31'b0, in_ready0}, 32'd1);
    step();
    in_valid0 = 1'b0;
    cyc = 1; vcyc = 0; ren_n = 0; wen_n = 0;
    while (vcyc == 0 && cyc <= 20) begin
      if (mem_ren0) begin
        ren_n++;
        raddr = mem_raddr0;
        rm    = mem_rmask0;
      end
      if (mem_wen0) begin
        wen_n++;
        waddr = mem_waddr0;
        wm    = mem_wmask0;
        wd    = mem_wdata0;
      end
      if (out_valid0) begin
        vcyc = cyc;
        rd   = out_rdata0;
        err  = out_err0;
      end else begin
        step();
        cyc++;
      end
    end
    chk({tag, " latency"}, 32'(vcyc), 32'(exp_lat));
    chk({tag, " ren cycles"}, 32'(ren_n), {31'b0, v.exp_ren});
    chk({tag, " wen cycles"}, 32'(wen_n), {31'b0, v.exp_wen});
    if (v.exp_ren) begin
      chk({tag, " raddr"}, raddr, v.exp_maddr);
      chk({tag, " rmask"}, {24'b0, rm}, {24'b0, v.exp_mask});
    end
    if (v.exp_wen) begin
      chk({tag, " waddr"}, waddr, v.exp_maddr);
      chk({tag, " wmask"}, {24'b0, wm}, {24'b0, v.exp_mask});
      chk({tag, " wdata"}, wd, v.exp_wdata);
    end
    chk({tag, " err"}, {31'b0, err}, {31'b0, v.exp_err});
    chk({tag, " rdata"}, rd, v.exp_rdata);
    step();
    chk({tag, " in_ready after"}, {31'b0, in_ready0}, 32'd1);
    chk({tag, " valid after"}, {30'b0, out_valid0, mem_ren0 | mem_wen0}, 32'd0);
  endtask

  initial begin
    int   cyc, vcyc, ren_n;
    logic bad;

    //          ld    st    f3      addr          wdata         mword
    //          ren   wen   maddr         mask   wdata         err   rdata
    vecs[0]  = '{1'b0, 1'b1, 3'b010, 32'h80000008, 32'hDEADBEEF, 32'h0,
                 1'b0, 1'b1, 32'h80000008, 8'h0F, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 3'b000, 32'h80000003, 32'h000000AB, 32'h0,
                 1'b0, 1'b1, 32'h80000000, 8'h08, 32'hAB000000, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'b000, 32'h80000001, 32'h0, 32'h123480FF,
                 1'b1, 1'b0, 32'h80000000, 8'h02, 32'h0, 1'b0, 32'hFFFFFF80};
    vecs[3]  = '{1'b1, 1'b0, 3'b100, 32'h80000001, 32'h0, 32'h123480FF,
                 1'b1, 1'b0, 32'h80000000, 8'h02, 32'h0, 1'b0, 32'h00000080};
    vecs[4]  = '{1'b1, 1'b0, 3'b001, 32'h80000003, 32'h0, 32'h123480FF,
                 1'b0, 1'b0, 32'h0, 8'h00, 32'h0, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h80000002, 32'h0, 32'h123480FF,
                 1'b0, 1'b0, 32'h0, 8'h00, 32'h0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 3'b001, 32'h80000002, 32'h0, 32'h80011234,
                 1'b1, 1'b0, 32'h80000000, 8'h0C, 32'h0, 1'b0, 32'hFFFF8001};
    vecs[7]  = '{1'b1, 1'b0, 3'b101, 32'h80000002, 32'h0, 32'h80011234,
                 1'b1, 1'b0, 32'h80000000, 8'h0C, 32'h0, 1'b0, 32'h00008001};
    vecs[8]  = '{1'b1, 1'b0, 3'b010, 32'h80000004, 32'h0, 32'hCAFEF00D,
                 1'b1, 1'b0, 32'h80000004, 8'h0F, 32'h0, 1'b0, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 1'b1, 3'b001, 32'h80000002, 32'h1234ABCD, 32'h0,
                 1'b0, 1'b1, 32'h80000000, 8'h0C, 32'hABCD0000, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 3'b010, 32'h80000000, 32'h11111111, 32'h22222222,
                 1'b0, 1'b0, 32'h0, 8'h00, 32'h0, 1'b1, 32'h0};
    vecs[11] = '{1'b0, 1'b1, 3'b100, 32'h80000000, 32'h11111111, 32'h0,
                 1'b0, 1'b0, 32'h0, 8'h00, 32'h0, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 1'b0, 3'b010, 32'h80000000, 32'h11111111, 32'h33333333,
                 1'b0, 1'b0, 32'h0, 8'h00, 32'h0, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 3'b000, 32'h80000003, 32'h0, 32'h7F0000AA,
                 1'b1, 1'b0, 32'h80000000, 8'h08, 32'h0, 1'b0, 32'h0000007F};
    vecs[14] = '{1'b0, 1'b1, 3'b010, 32'h80000001, 32'h55555555, 32'h0,
                 1'b0, 1'b0, 32'h0, 8'h00, 32'h0, 1'b1, 32'h0};

    rst = 1'b1;
    in_valid0 = 1'b0; out_ready0 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0;
    in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b000;
    in_addr = '0; in_wdata = '0; mem_rdata = '0;
    step();
    step();
    rst = 1'b0;

    chk("reset in_ready", {31'b0, in_ready0}, 32'd1);
    chk("reset out_valid/err/en", {28'b0, out_valid0, out_err0, mem_ren0, mem_wen0}, 32'd0);
    chk("reset out_rdata", out_rdata0, 32'd0);
    chk("reset addrs", mem_raddr0 | mem_waddr0, 32'd0);
    chk("reset masks", {16'b0, mem_rmask0, mem_wmask0}, 32'd0);
    chk("reset wdata", mem_wdata0, 32'd0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Three-cycle memory latency with a stalled consumer.
    in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'b010;
    in_addr = 32'h80000004; mem_rdata = 32'h0BADF00D;
    out_ready3 = 1'b0; in_valid3 = 1'b1;
    step();
    in_valid3 = 1'b0;
    chk("w3 issue ren", {31'b0, mem_ren3}, 32'd1);
    chk("w3 issue raddr", mem_raddr3, 32'h80000004);
    chk("w3 issue rmask", {24'b0, mem_rmask3}, 32'h0F);
    in_addr = 32'h80000001; in_funct3 = 3'b000;
    bad = in_ready3;
    step();
    mem_rdata = 32'hFFFFFFFF;
    in_valid3 = 1'b1;
    cyc = 2; vcyc = 0; ren_n = 0;
    while (vcyc == 0 && cyc <= 20) begin
      if (mem_ren3 || mem_wen3) ren_n++;
      if (in_ready3) bad = 1'b1;
      if (out_valid3) vcyc = cyc;
      else begin
        step();
        cyc++;
      end
    end
    in_valid3 = 1'b0;
    chk("w3 valid cycle", 32'(vcyc), 32'd5);
    chk("w3 extra enables", 32'(ren_n), 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (out_valid3 !== 1'b1 || out_rdata3 !== 32'h0BADF00D || out_err3 !== 1'b0) bad = 1'b1;
      if (in_ready3 || mem_ren3 || mem_wen3) bad = 1'b1;
      step();
    end
    chk("w3 stall stable", {31'b0, bad}, 32'd0);
    chk("w3 rdata at handshake", out_rdata3, 32'h0BADF00D);
    out_ready3 = 1'b1;
    step();
    out_ready3 = 1'b0;
    chk("w3 valid after hs", {31'b0, out_valid3}, 32'd0);
    chk("w3 in_ready after hs", {31'b0, in_ready3}, 32'd1);

    // Reset during the wait after an issued load drops the response.
    in_funct3 = 3'b010; in_addr = 32'h80000008; mem_rdata = 32'h44444444;
    in_valid3 = 1'b1;
    step();
    in_valid3 = 1'b0;
    chk("rst issue ren", {31'b0, mem_ren3}, 32'd1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst in_ready", {31'b0, in_ready3}, 32'd1);
    chk("rst out_valid", {31'b0, out_valid3}, 32'd0);
    chk("rst raddr", mem_raddr3, 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (mem_ren3 || mem_wen3 || out_valid3 || !in_ready3) bad = 1'b1;
      step();
    end
    chk("rst quiet", {31'b0, bad}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060201_lsu.md
Name: ysyx_23060201_lsu

Overview:
Load/store unit sitting directly upstream of the data-memory block. Accepts one decoded memory op from EXU via valid/ready, drives the memory read/write ports for exactly one cycle, extracts and extends load data, and returns the result to WBU via valid/ready. Owns alignment checks, byte-lane masking and the memory-latency wait.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data width; fixed at 32 for this design
WAIT_CYCLES, 0, extra cycles between issue and response; models memory latency, range 0..15

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  EXU op valid
in_ready  out  1  LSU can accept an op
in_is_load  in  1  load op
in_is_store  in  1  store op
in_funct3  in  3  RV32 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_addr  in  32  effective byte address
in_wdata  in  32  store data, right-aligned
out_valid  out  1  result valid to WBU
out_ready  in  1  WBU accepts result
out_rdata  out  32  extended load data; 0 for stores and errors
out_err  out  1  misaligned or illegal op
mem_ren  out  1  read enable
mem_raddr  out  32  word-aligned read address
mem_rmask  out  8  byte-lane mask; bits [7:4] always 0
mem_rdata  in  32  full word from memory
mem_wen  out  1  write enable; memory writes on posedge
mem_waddr  out  32  word-aligned write address
mem_wmask  out  8  byte-lane mask; bits [7:4] always 0
mem_wdata  out  32  lane-shifted store data

Behaviour:
- Reset, synchronous and active-high: state IDLE; in_ready 1; out_valid 0; out_rdata 0; out_err 0; mem_ren 0; mem_wen 0; all mem address, mask and data outputs 0; wait counter 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: in_ready is 1 only in this state. On in_valid, latch op, addr, wdata and funct3, then go to ISSUE (cycle 0 to 1).
- In IDLE, a legality check decides the path:
  - Illegal: both is_load and is_store set, a funct3 not listed for that op, or misaligned (H with addr[0]=1, W with addr[1:0]!=0). Skip ISSUE, go straight to DONE with out_err=1 and out_rdata=0. No memory enable is ever raised.
  - Neither load nor store: go to DONE with out_err=0, out_rdata=0, no access.
- ISSUE lasts exactly 1 cycle:
  - Address: mem_raddr/mem_waddr = {addr[31:2],2'b00}.
  - Mask: B gives 4'b0001<<addr[1:0]; H gives 4'b0011<<addr[1:0]; W gives 4'b1111.
  - Store: mem_wen=1, mem_wdata = wdata<<(8*addr[1:0]).
  - Load: mem_ren=1; mem_rdata is captured at the end of this cycle.
  - Both enables drop at the next edge; an enable is never high for more than 1 cycle per op.
- Leaving ISSUE: if WAIT_CYCLES=0, go to DONE. Otherwise go to WAIT, count WAIT_CYCLES cycles, then go to DONE.
- Load extraction: shift the captured word right by 8*addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.
- DONE: out_valid=1 with out_rdata/out_err held stable until out_ready.
  - On out_valid&&out_ready: go to IDLE; in_ready returns 1 the following cycle. No bypass to accept a new op in the same cycle.
- Minimum latency (WAIT_CYCLES=0, out_ready=1): accept in cycle 0, issue in cycle 1, out_valid in cycle 2, IDLE in cycle 3.
- Inputs are ignored outside IDLE; in_valid while busy is not an error.
- Reset mid-op:
  - A write whose mem_wen is already high at the reset edge completes, because the memory samples it at that edge.
  - No new enable is raised after reset, and the pending response is dropped.

Decomposition:
- Shared package/defines: funct3 encodings, FSM state encodings, lane-mask constants.
- One natural sub-module, ysyx_23060201_lsu_align. It is purely combinational and produces the wmask, the shifted wdata and the extended rdata from funct3, addr[1:0] and data. The FSM stays in the top module.

Test Plan:
- SW addr 0x80000008 data 0xDEADBEEF -> one-cycle mem_wen, waddr 0x80000008, wmask 0x0F, wdata 0xDEADBEEF; out_valid at cycle 2, err 0.
- SB addr 0x80000003 data 0x000000AB -> waddr 0x80000000, wmask 0x08, wdata 0xAB000000.
- LB/LBU addr 0x80000001 with mem word 0x1234_80FF -> raddr 0x80000000, rmask 0x02; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- LH addr 0x80000003 -> out_err 1, out_rdata 0, mem_ren/mem_wen never asserted; LW at offset 2 gives the same.
- WAIT_CYCLES=3, out_ready held low 5 cycles after out_valid -> out_valid appears at cycle 5; out_rdata stable while stalled; in_ready 0 throughout, then 1 one cycle after the handshake.
- Reset asserted in WAIT after an issued load -> next cycle state IDLE, out_valid 0, in_ready 1, no further mem enables.
